// File: rtl/wb_pkg.sv
// Shared types, constants and helpers for the writeback stage.
package wb_pkg;

  // Load access size as encoded by the MEM stage; 2'b11 is handled as a word.
  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10
  } load_size_t;

  // Writeback stage control states.
  typedef enum logic [1:0] {
    WB_IDLE      = 2'b00,
    WB_WAIT_LOAD = 2'b01,
    WB_COMMIT    = 2'b10
  } wb_state_t;

  // Register written by a link, and the return offset the register bench adds.
  localparam logic [4:0]  LINK_REG    = 5'd31;
  localparam logic [31:0] LINK_OFFSET = 32'd4;

  // Instruction fields held while a load waits for its data.
  typedef struct packed {
    logic [4:0] rd;
    logic       link_flag;
    logic       set_flag;
    logic       cond_flag;
    logic [1:0] size;
    logic       zero_ext;
    logic [1:0] lsb;
  } wb_pend_t;

  // Everything the register bench write port presents during a commit.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] word;
    logic        link_flag;
    logic        set_flag;
    logic        cond_flag;
  } wb_commit_t;

  // A commit writes only a real register, or r31 through the link path.
  function automatic logic write_en_f(input logic [4:0] rd, input logic link_flag);
    return (rd != 5'd0) || link_flag;
  endfunction

  // Register that actually changes: link always lands in r31.
  function automatic logic [4:0] fwd_rd_f(input logic [4:0] rd, input logic link_flag);
    logic [4:0] r;
    if (link_flag) begin
      r = LINK_REG;
    end else begin
      r = rd;
    end
    return r;
  endfunction

  // Value the destination register holds once the register bench has written it.
  function automatic logic [31:0] fwd_value_f(input logic [31:0] word, input logic link_flag,
                                              input logic set_flag, input logic cond_flag);
    logic [31:0] v;
    if (link_flag) begin
      v = word + LINK_OFFSET;
    end else if (set_flag) begin
      v = {31'd0, cond_flag};
    end else begin
      v = word;
    end
    return v;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane of a read word
// and sign- or zero-extends it. Purely combinational so the store-forwarding
// path can reuse it.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lsb_i,
  input  logic        zero_ext_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        byte_fill_s;
  logic        half_fill_s;

  // Lane select: byte by full offset, halfword by offset bit 1 only.
  always_comb begin
    byte_s = rdata_i[7:0];
    case (lsb_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    if (lsb_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
  end

  assign byte_fill_s = byte_s[7] & ~zero_ext_i;
  assign half_fill_s = half_s[15] & ~zero_ext_i;

  // Extend the selected lane to the full register width.
  always_comb begin
    data_o = rdata_i;
    case (size_i)
      LS_BYTE: data_o = {{24{byte_fill_s}}, byte_s};
      LS_HALF: data_o = {{16{half_fill_s}}, half_s};
      LS_WORD: data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts one retiring instruction per cycle, waits (bounded)
// for load data, drives the register bench write port for one cycle per
// instruction and publishes a registered forwarding bundle.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic        in_is_load,
  input  logic [1:0]  in_load_size,
  input  logic        in_load_unsigned,
  input  logic [1:0]  in_addr_lsb,
  input  logic        in_link,
  input  logic        in_set,
  input  logic        in_condition,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        enable_reg,
  output logic [4:0]  Rd_back,
  output logic [31:0] word_back,
  output logic        link_back,
  output logic        set_back,
  output logic        condition_back,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_value,
  output logic        load_timeout
);

  // Wait counter limit; the counter is 8 bits wide since the limit is at most 255.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(LOAD_TIMEOUT);

  wb_state_t   state_q;
  logic [7:0]  wait_cnt_q;
  wb_pend_t    pend_q;
  wb_commit_t  out_q;
  logic        enable_q;
  logic        fwd_valid_q;
  logic [4:0]  fwd_rd_q;
  logic [31:0] fwd_value_q;
  logic        timeout_q;

  logic        accept_s;
  logic        wait_done_s;
  logic [31:0] aligned_s;
  wb_pend_t    in_pend_s;
  wb_commit_t  direct_s;
  wb_commit_t  load_s;
  wb_commit_t  commit_s;
  logic        commit_en_s;
  logic [4:0]  commit_fwd_rd_s;
  logic [31:0] commit_fwd_value_s;

  // Only a pending load stalls the MEM stage.
  assign in_ready = (state_q != WB_WAIT_LOAD);
  assign accept_s = in_valid && in_ready;

  // A pending load finishes on data, or when the wait budget runs out.
  assign wait_done_s = mem_rvalid || (wait_cnt_q == TIMEOUT_LIMIT);

  load_align u_load_align (
    .rdata_i    (mem_rdata),
    .size_i     (pend_q.size),
    .lsb_i      (pend_q.lsb),
    .zero_ext_i (pend_q.zero_ext),
    .data_o     (aligned_s)
  );

  // Build the incoming-load record, both candidate commit bundles and the
  // write-enable / forwarding view of whichever one commits next.
  always_comb begin
    in_pend_s           = '0;
    in_pend_s.rd        = in_rd;
    in_pend_s.link_flag = in_link;
    in_pend_s.set_flag  = in_set;
    in_pend_s.cond_flag = in_condition;
    in_pend_s.size      = in_load_size;
    in_pend_s.zero_ext  = in_load_unsigned;
    in_pend_s.lsb       = in_addr_lsb;

    direct_s           = '0;
    direct_s.rd        = in_rd;
    direct_s.word      = in_result;
    direct_s.link_flag = in_link;
    direct_s.set_flag  = in_set;
    direct_s.cond_flag = in_condition;

    // Data wins over the timeout when both happen in the same cycle.
    load_s           = '0;
    load_s.rd        = pend_q.rd;
    load_s.link_flag = pend_q.link_flag;
    load_s.set_flag  = pend_q.set_flag;
    load_s.cond_flag = pend_q.cond_flag;
    if (mem_rvalid) begin
      load_s.word = aligned_s;
    end else begin
      load_s.word = 32'h0000_0000;
    end

    if (state_q == WB_WAIT_LOAD) begin
      commit_s = load_s;
    end else begin
      commit_s = direct_s;
    end

    commit_en_s        = write_en_f(commit_s.rd, commit_s.link_flag);
    commit_fwd_rd_s    = fwd_rd_f(commit_s.rd, commit_s.link_flag);
    commit_fwd_value_s = fwd_value_f(commit_s.word, commit_s.link_flag,
                                     commit_s.set_flag, commit_s.cond_flag);
  end

  // Stage FSM: accept, wait for load data, and register the write and forwarding outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WB_IDLE;
      wait_cnt_q  <= 8'd0;
      pend_q      <= '0;
      out_q       <= '0;
      enable_q    <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= 5'd0;
      fwd_value_q <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        WB_IDLE, WB_COMMIT: begin
          if (accept_s && in_is_load) begin
            pend_q      <= in_pend_s;
            wait_cnt_q  <= 8'd0;
            enable_q    <= 1'b0;
            fwd_valid_q <= 1'b0;
            state_q     <= WB_WAIT_LOAD;
          end else if (accept_s) begin
            out_q       <= commit_s;
            enable_q    <= commit_en_s;
            fwd_valid_q <= commit_en_s;
            fwd_rd_q    <= commit_fwd_rd_s;
            fwd_value_q <= commit_fwd_value_s;
            state_q     <= WB_COMMIT;
          end else begin
            enable_q    <= 1'b0;
            fwd_valid_q <= 1'b0;
            state_q     <= WB_IDLE;
          end
        end
        WB_WAIT_LOAD: begin
          if (wait_done_s) begin
            out_q       <= commit_s;
            enable_q    <= commit_en_s;
            fwd_valid_q <= commit_en_s;
            fwd_rd_q    <= commit_fwd_rd_s;
            fwd_value_q <= commit_fwd_value_s;
            state_q     <= WB_COMMIT;
            // Abandoned loads are latched as an error until the next reset.
            if (!mem_rvalid) begin
              timeout_q <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: begin
          enable_q    <= 1'b0;
          fwd_valid_q <= 1'b0;
          state_q     <= WB_IDLE;
        end
      endcase
    end
  end

  assign enable_reg     = enable_q;
  assign Rd_back        = out_q.rd;
  assign word_back      = out_q.word;
  assign link_back      = out_q.link_flag;
  assign set_back       = out_q.set_flag;
  assign condition_back = out_q.cond_flag;
  assign fwd_valid      = fwd_valid_q;
  assign fwd_rd         = fwd_rd_q;
  assign fwd_value      = fwd_value_q;
  assign load_timeout   = timeout_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases from the stage's documented
// behaviour followed by randomized instruction streams against a transaction-
// level reference model.
module tb_wb_stage;

  localparam int unsigned T = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] in_result = 32'd0;
  logic        in_is_load = 1'b0;
  logic [1:0]  in_load_size = 2'd0;
  logic        in_load_unsigned = 1'b0;
  logic [1:0]  in_addr_lsb = 2'd0;
  logic        in_link = 1'b0;
  logic        in_set = 1'b0;
  logic        in_condition = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        enable_reg;
  logic [4:0]  Rd_back;
  logic [31:0] word_back;
  logic        link_back;
  logic        set_back;
  logic        condition_back;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_value;
  logic        load_timeout;

  wb_stage #(.LOAD_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_result(in_result), .in_is_load(in_is_load),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_addr_lsb(in_addr_lsb), .in_link(in_link), .in_set(in_set),
    .in_condition(in_condition), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .enable_reg(enable_reg), .Rd_back(Rd_back), .word_back(word_back),
    .link_back(link_back), .set_back(set_back), .condition_back(condition_back),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_value(fwd_value),
    .load_timeout(load_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference view of the register bench port (values hold between commits).
  logic [4:0]  m_rd;
  logic [31:0] m_word;
  logic        m_link;
  logic        m_set;
  logic        m_cond;
  logic        m_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Load result from the architectural rule, using plain arithmetic.
  function automatic logic [31:0] exp_align(input logic [31:0] d, input logic [1:0] size,
                                            input logic uns, input logic [1:0] lsb);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (d >> (8 * int'(lsb))) & 32'h0000_00FF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (d >> (16 * int'(lsb[1]))) & 32'h0000_FFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_rd = 5'd0; m_word = 32'd0; m_link = 1'b0; m_set = 1'b0; m_cond = 1'b0; m_to = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, in_ready, 1);
    check_eq({tag, "_en"}, enable_reg, 0);
    check_eq({tag, "_rd"}, Rd_back, 0);
    check_eq({tag, "_word"}, word_back, 0);
    check_eq({tag, "_flags"}, {link_back, set_back, condition_back}, 0);
    check_eq({tag, "_fwdv"}, fwd_valid, 0);
    check_eq({tag, "_fwdrd"}, fwd_rd, 0);
    check_eq({tag, "_fwdval"}, fwd_value, 0);
    check_eq({tag, "_timeout"}, load_timeout, 0);
  endtask

  // Commit cycle: write port and forwarding bundle follow the model.
  task automatic expect_commit(input string tag);
    logic        en;
    logic [4:0]  frd;
    logic [31:0] fv;
    en  = (m_rd != 5'd0) || m_link;
    frd = m_link ? 5'd31 : m_rd;
    if (m_link) fv = m_word + 32'd4;
    else if (m_set) fv = {31'd0, m_cond};
    else fv = m_word;
    check_eq({tag, "_en"}, enable_reg, en);
    check_eq({tag, "_rd"}, Rd_back, m_rd);
    check_eq({tag, "_word"}, word_back, m_word);
    check_eq({tag, "_flags"}, {link_back, set_back, condition_back}, {m_link, m_set, m_cond});
    check_eq({tag, "_fwdv"}, fwd_valid, en);
    if (en) begin
      check_eq({tag, "_fwdrd"}, fwd_rd, frd);
      check_eq({tag, "_fwdval"}, fwd_value, fv);
    end
    check_eq({tag, "_timeout"}, load_timeout, m_to);
  endtask

  // Idle cycle with stray read-valid noise: nothing commits, values hold.
  task automatic idle_cycle(input string tag);
    in_valid = 1'b0;
    mem_rvalid = 1'($urandom % 2);
    mem_rdata = $urandom;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq({tag, "_en"}, enable_reg, 0);
    check_eq({tag, "_fwdv"}, fwd_valid, 0);
    check_eq({tag, "_ready"}, in_ready, 1);
    check_eq({tag, "_hold_rd"}, Rd_back, m_rd);
    check_eq({tag, "_hold_word"}, word_back, m_word);
    check_eq({tag, "_timeout"}, load_timeout, m_to);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    mem_rvalid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all_zero("reset");
  endtask

  task automatic issue_nonload(input logic [4:0] rd, input logic [31:0] res,
                               input logic link, input logic set, input logic cond);
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_result = res;
    in_link = link; in_set = set; in_condition = cond;
    in_load_size = 2'($urandom); in_load_unsigned = 1'($urandom); in_addr_lsb = 2'($urandom);
    mem_rvalid = 1'($urandom % 2); mem_rdata = $urandom;
    @(negedge clk);
    in_valid = 1'b0; mem_rvalid = 1'b0;
    m_rd = rd; m_word = res; m_link = link; m_set = set; m_cond = cond;
    check_eq("nl_ready", in_ready, 1);
    expect_commit("nl");
  endtask

  // Load whose data arrives 'delay' cycles after acceptance (never if > T+1).
  task automatic issue_load(input logic [4:0] rd, input logic link, input logic set,
                            input logic cond, input logic [1:0] size, input logic uns,
                            input logic [1:0] lsb, input logic [31:0] rdata, input int delay);
    int ready_low;
    int exp_low;
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_result = $urandom;
    in_link = link; in_set = set; in_condition = cond;
    in_load_size = size; in_load_unsigned = uns; in_addr_lsb = lsb;
    mem_rvalid = 1'($urandom % 2); mem_rdata = $urandom;
    @(negedge clk);
    in_valid = 1'b0; mem_rvalid = 1'b0;
    ready_low = 0;
    for (int k = 1; k <= int'(T) + 1; k++) begin
      if (in_ready === 1'b0) ready_low++;
      if (k == delay) begin
        mem_rvalid = 1'b1; mem_rdata = rdata;
      end else begin
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (k >= delay) break;
    end
    exp_low = (delay <= int'(T) + 1) ? delay : int'(T) + 1;
    check_eq("ld_ready_low", ready_low, exp_low);
    check_eq("ld_ready_after", in_ready, 1);
    m_rd = rd; m_link = link; m_set = set; m_cond = cond;
    if (delay <= int'(T) + 1) begin
      m_word = exp_align(rdata, size, uns, lsb);
    end else begin
      m_word = 32'd0;
      m_to = 1'b1;
    end
    expect_commit("ld");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Simple non-load commit, then an idle cycle.
    issue_nonload(5'd5, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    check_eq("t1_en", enable_reg, 1);
    check_eq("t1_word", word_back, 32'h0000_1234);
    idle_cycle("t1_idle");

    // Back-to-back non-loads commit one per cycle.
    issue_nonload(5'd7, 32'hAAAA_0001, 1'b0, 1'b1, 1'b1);
    issue_nonload(5'd8, 32'hAAAA_0002, 1'b0, 1'b0, 1'b1);
    issue_nonload(5'd9, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);

    // Signed byte load, lane 2, data three cycles after accept.
    issue_load(5'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 32'h0080_0000, 3);
    check_eq("t2_word", word_back, 32'hFFFF_FF80);

    // Unsigned halfword load at offset 3 uses the upper half.
    issue_load(5'd4, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 2'd3, 32'hBEEF_0000, 1);
    check_eq("t3_word", word_back, 32'h0000_BEEF);

    // Link to r0 still writes r31 with return address + 4; plain r0 writes nothing.
    issue_nonload(5'd0, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
    check_eq("t4_en", enable_reg, 1);
    check_eq("t4_fwdrd", fwd_rd, 31);
    check_eq("t4_fwdval", fwd_value, 32'h0000_0104);
    issue_nonload(5'd0, 32'h1357_9BDF, 1'b0, 1'b0, 1'b0);
    check_eq("t4_r0_en", enable_reg, 0);

    // Data exactly at the timeout edge wins: no error.
    issue_load(5'd6, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 32'hCAFE_F00D, int'(T) + 1);
    check_eq("t5_word", word_back, 32'hCAFE_F00D);
    check_eq("t5_no_to", load_timeout, 0);

    // No data at all: commit of zero after T+1 cycles, sticky error.
    issue_load(5'd10, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 32'h1234_5678, 1000);
    check_eq("t6_word", word_back, 32'h0000_0000);
    check_eq("t6_to", load_timeout, 1);
    idle_cycle("t6_idle1");
    issue_nonload(5'd11, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
    idle_cycle("t6_idle2");

    // Reset in the middle of a load wait, then a stray read-valid.
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd12; in_load_size = 2'd2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t7_waiting", in_ready, 0);
    do_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_all_zero("t7_stray");
    @(negedge clk);
    check_all_zero("t7_after");

    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      int r;
      logic [4:0] rd;
      r  = int'($urandom % 10);
      rd = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      if ($urandom % 60 == 0) begin
        do_reset();
      end else if (r < 5) begin
        issue_nonload(rd, $urandom, 1'($urandom % 4 == 0), 1'($urandom % 4 == 0), 1'($urandom));
      end else if (r < 9) begin
        issue_load(rd, 1'($urandom % 6 == 0), 1'($urandom % 6 == 0), 1'($urandom),
                   2'($urandom), 1'($urandom), 2'($urandom), $urandom,
                   int'($urandom_range(1, T + 3)));
      end else begin
        idle_cycle("rnd_idle");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
